daq_uart_tx: RTL



---
 rtl/daq_uart_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/daq_uart_tx.sv
// 8N1 UART serializer; after each s_tlast byte it appends the CRC-16/CCITT-FALSE of the packet (when CRC_EN).
// One frame per 10*CLKS_PER_BIT cycles plus one IDLE cycle; s_tready only in IDLE with no CRC byte pending.
module daq_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit CRC_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic        uart_txd,
   output logic        busy,
   output logic        pkt_done,
   output logic [15:0] pkt_count
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [1:0] SRC_PAYLOAD = 2'd0;
   localparam logic [1:0] SRC_CRC_HI  = 2'd1;
   localparam logic [1:0] SRC_CRC_LO  = 2'd2;

   localparam int          CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    state_q, state_d;
   logic [1:0]    src_q, src_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          last_q, last_d;
   logic [15:0]   crc_q, crc_d;
   logic          txd_q, txd_d;
   logic          done_q, done_d;
   logic [15:0]   pkt_count_q, pkt_count_d;
   logic          bit_end;
   logic          accept;
   logic          pkt_end;

   function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   assign bit_end   = (clk_cnt_q == BIT_LAST);
   assign s_tready  = !rst && (state_q == ST_IDLE) && (src_q == SRC_PAYLOAD);
   assign accept    = s_tvalid && s_tready;
   assign uart_txd  = txd_q;
   assign busy      = (state_q != ST_IDLE) || (src_q != SRC_PAYLOAD);
   assign pkt_done  = done_q;
   assign pkt_count = pkt_count_q;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      last_d      = last_q;
      crc_d       = crc_q;
      txd_d       = txd_q;
      done_d      = 1'b0;
      pkt_count_d = pkt_count_q;
      pkt_end     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clk_cnt_d = '0;
            if (src_q == SRC_CRC_HI) begin
               shift_d = crc_q[15:8];
               state_d = ST_START;
               txd_d   = 1'b0;
            end else if (src_q == SRC_CRC_LO) begin
               shift_d = crc_q[7:0];
               state_d = ST_START;
               txd_d   = 1'b0;
            end else if (accept) begin
               shift_d = s_tdata;
               last_d  = s_tlast;
               crc_d   = crc16_upd(crc_q, s_tdata);
               state_d = ST_START;
               txd_d   = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = ST_DATA;
               txd_d     = shift_q[0];
               shift_d   = shift_q >> 1;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = ST_IDLE;
               // The trailer follows the last payload byte; the packet closes after CRC_LO.
               case (src_q)
                  SRC_PAYLOAD: begin
                     if (last_q) begin
                        if (CRC_EN) src_d = SRC_CRC_HI;
                        else        pkt_end = 1'b1;
                     end
                  end
                  SRC_CRC_HI: src_d = SRC_CRC_LO;
                  default: begin
                     src_d   = SRC_PAYLOAD;
                     pkt_end = 1'b1;
                  end
               endcase
               if (pkt_end) begin
                  done_d      = 1'b1;
                  pkt_count_d = pkt_count_q + 16'd1;
                  crc_d       = 16'hFFFF;
                  last_d      = 1'b0;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         src_q       <= SRC_PAYLOAD;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         last_q      <= 1'b0;
         crc_q       <= 16'hFFFF;
         txd_q       <= 1'b1;
         done_q      <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         last_q      <= last_d;
         crc_q       <= crc_d;
         txd_q       <= txd_d;
         done_q      <= done_d;
         pkt_count_q <= pkt_count_d;
      end
   end
endmodule
